// File: rtl/hall_angle_sequencer.sv
// Hall code to 10-bit electrical angle: sync + debounce, sector/direction
// tracking, period measurement and per-sector Bresenham interpolation.
module hall_angle_sequencer #(
  parameter int          PERIOD_W    = 20,
  parameter int unsigned STALL_LIMIT = 20'hFFFFF,
  parameter int          DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall,
  input  logic       enable,
  output logic [2:0] hall_stable,
  output logic [2:0] sector,
  output logic       dir,
  output logic [9:0] angle_out,
  output logic       angle_valid,
  output logic [1:0] fault
);

  localparam logic [PERIOD_W-1:0] STALL_CNT = PERIOD_W'(STALL_LIMIT);
  localparam logic [3:0]          DB_CNT    = 4'(DEBOUNCE);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_MEASURE, S_RUN, S_FAULT} state_t;

  // {valid, sector} for a Hall code; 000/111 decode as invalid
  function automatic logic [3:0] decode(input logic [2:0] c);
    case (c)
      3'b011:  decode = {1'b1, 3'd0};
      3'b001:  decode = {1'b1, 3'd1};
      3'b101:  decode = {1'b1, 3'd2};
      3'b100:  decode = {1'b1, 3'd3};
      3'b110:  decode = {1'b1, 3'd4};
      3'b010:  decode = {1'b1, 3'd5};
      default: decode = 4'b0;
    endcase
  endfunction

  // round(1024 * s / 6)
  function automatic logic [9:0] base_of(input logic [2:0] s);
    case (s)
      3'd0:    base_of = 10'd0;
      3'd1:    base_of = 10'd171;
      3'd2:    base_of = 10'd341;
      3'd3:    base_of = 10'd512;
      3'd4:    base_of = 10'd683;
      default: base_of = 10'd853;
    endcase
  endfunction

  logic [2:0] hall_s1, hall_s2, cand;
  logic [3:0] db_cnt, db_cnt_nxt;
  logic       db_upd;

  state_t              state, state_n;
  logic [2:0]          sector_n;
  logic                dir_n;
  logic [9:0]          angle_n;
  logic [1:0]          fault_n;
  logic [PERIOD_W-1:0] elapsed, elapsed_n, elapsed_inc;
  logic [PERIOD_W-1:0] period, period_n;
  logic [PERIOD_W-1:0] acc, acc_n;
  logic [PERIOD_W:0]   acc_sum;
  logic [7:0]          offset, offset_n;

  logic [3:0] cur_dec, new_dec, nxt_dec;
  logic [2:0] sec_up, sec_dn;
  logic       is_fwd, is_rev;

  // debounce count of consecutive identical synchronised samples
  always_comb begin
    db_cnt_nxt = 4'd1;
    if (hall_s2 == cand)
      db_cnt_nxt = (db_cnt == DB_CNT) ? db_cnt : db_cnt + 4'd1;
  end

  // accepted edge: the debounced code is about to change this cycle
  assign db_upd = (db_cnt_nxt == DB_CNT) && (hall_s2 != hall_stable);

  // 2-FF synchroniser and debounced code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1     <= '0;
      hall_s2     <= '0;
      cand        <= '0;
      db_cnt      <= '0;
      hall_stable <= '0;
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
      cand    <= hall_s2;
      db_cnt  <= db_cnt_nxt;
      if (db_upd) hall_stable <= hall_s2;
    end
  end

  // classify the incoming code against the sector of the current stable code
  assign cur_dec = decode(hall_stable);
  assign new_dec = decode(hall_s2);
  assign nxt_dec = decode(db_upd ? hall_s2 : hall_stable);
  assign sec_up  = (cur_dec[2:0] == 3'd5) ? 3'd0 : cur_dec[2:0] + 3'd1;
  assign sec_dn  = (cur_dec[2:0] == 3'd0) ? 3'd5 : cur_dec[2:0] - 3'd1;
  assign is_fwd  = cur_dec[3] && new_dec[3] && (new_dec[2:0] == sec_up);
  assign is_rev  = cur_dec[3] && new_dec[3] && (new_dec[2:0] == sec_dn);

  assign elapsed_inc = (elapsed == STALL_CNT) ? elapsed : elapsed + PERIOD_W'(1);
  assign acc_sum     = {1'b0, acc} + (PERIOD_W+1)'(171);

  // next state and datapath; edges override the interpolation update
  always_comb begin
    state_n   = state;
    sector_n  = sector;
    dir_n     = dir;
    angle_n   = angle_out;
    fault_n   = fault;
    elapsed_n = elapsed;
    period_n  = period;
    acc_n     = acc;
    offset_n  = offset;
    if (!enable) begin
      state_n = S_IDLE;
      fault_n = 2'd0;
    end else begin
      case (state)
        S_IDLE: state_n = S_ALIGN;
        S_ALIGN: begin
          if (nxt_dec[3]) begin
            sector_n = nxt_dec[2:0];
            angle_n  = base_of(nxt_dec[2:0]) + 10'd85;
          end
          if (db_upd && (is_fwd || is_rev)) begin
            dir_n     = is_fwd;
            elapsed_n = '0;
            fault_n   = 2'd0;
            state_n   = S_MEASURE;
          end
        end
        S_MEASURE, S_RUN: begin
          elapsed_n = elapsed_inc;
          if (state == S_RUN) begin
            if (offset != 8'd170) begin
              if (acc_sum >= {1'b0, period}) begin
                acc_n    = PERIOD_W'(acc_sum - {1'b0, period});
                offset_n = offset + 8'd1;
              end else begin
                acc_n = acc_sum[PERIOD_W-1:0];
              end
            end
            angle_n = base_of(sector) + (dir ? {2'b0, offset} : 10'd170 - {2'b0, offset});
          end
          if (db_upd) begin
            if (!new_dec[3]) begin
              fault_n = 2'd1;
              state_n = S_FAULT;
            end else if (is_fwd || is_rev) begin
              sector_n = new_dec[2:0];
              if (is_fwd == dir) begin
                period_n  = elapsed + PERIOD_W'(1);
                elapsed_n = '0;
                acc_n     = '0;
                offset_n  = '0;
                angle_n   = dir ? base_of(new_dec[2:0]) : base_of(new_dec[2:0]) + 10'd170;
                fault_n   = 2'd0;
                state_n   = S_RUN;
              end else begin
                angle_n = base_of(new_dec[2:0]) + 10'd85;
                state_n = S_ALIGN;
              end
            end else begin
              fault_n = 2'd2;
              state_n = S_FAULT;
            end
          end else if (elapsed_inc == STALL_CNT) begin
            fault_n = 2'd3;
            state_n = S_ALIGN;
          end
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sector    <= '0;
      dir       <= 1'b1;
      angle_out <= '0;
      fault     <= '0;
      elapsed   <= '0;
      period    <= '0;
      acc       <= '0;
      offset    <= '0;
    end else begin
      state     <= state_n;
      sector    <= sector_n;
      dir       <= dir_n;
      angle_out <= angle_n;
      fault     <= fault_n;
      elapsed   <= elapsed_n;
      period    <= period_n;
      acc       <= acc_n;
      offset    <= offset_n;
    end
  end

  assign angle_valid = (state == S_RUN);

endmodule
